// File: rtl/aes_step_sequencer.sv
// -----------------------------------------------------------------------------
// aes_step_sequencer
//
// Purpose:
//   Drives the enable of the 5-bit LFSR step counter in the AES controller and
//   turns each step into binary step/round/phase indices and datapath enables.
//   On completion it raises a held done that the consumer acknowledges.
//
// Optional build macro:
//   SEQ_CHECK_EN - when defined, each LFSR code is decoded back to a binary step
//                  and compared with the shadow step count. Any disagreement,
//                  including an illegal code, sends the FSM to ERR and raises
//                  seq_err until err_clr. When undefined, state_counter and
//                  err_clr are unused, seq_err is 0 and ERR cannot be reached.
//
// Parameters:
//   NUM_STEPS     steps per operation; even, 2..20; two steps per round
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-low reset
//   start         operation request, accepted only while start_ready=1
//   start_ready   high in IDLE
//   abort         cancels a running operation (priority over everything in RUN)
//   done          operation complete, held until done_ack
//   done_ack      consumer acknowledge of done
//   err_clr       leaves ERR
//   state_counter LFSR code from the step counter
//   en_signal     counter enable; low makes the counter hold code 1
//   busy          high in RUN
//   step_idx      binary step 0..NUM_STEPS-1 (0 outside RUN)
//   round_idx     step_idx >> 1
//   phase         step_idx[0]
//   last_round    round_idx == NUM_STEPS/2-1
//   key_exp_en    phase == 0
//   mix_en        phase == 1 and not last_round
//   seq_err       sequence-mismatch flag, held while in ERR
// -----------------------------------------------------------------------------
module aes_step_sequencer #(
  parameter int unsigned NUM_STEPS = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       start_ready,
  input  logic       abort,
  output logic       done,
  input  logic       done_ack,
  input  logic       err_clr,
  input  logic [4:0] state_counter,
  output logic       en_signal,
  output logic       busy,
  output logic [4:0] step_idx,
  output logic [3:0] round_idx,
  output logic       phase,
  output logic       last_round,
  output logic       key_exp_en,
  output logic       mix_en,
  output logic       seq_err
);

  localparam logic [4:0] LAST_STEP  = 5'(NUM_STEPS - 1);
  localparam logic [3:0] LAST_ROUND = 4'(NUM_STEPS / 2 - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [4:0] r_step;
  logic [4:0] w_step_nxt;
  logic       w_run;
  logic       w_mismatch;

`ifdef SEQ_CHECK_EN
  logic       w_dec_valid;
  logic [4:0] w_dec_step;

  // Inverse of the counter's code table. Codes outside the table decode as
  // invalid, so they can never match any shadow step.
  always_comb begin
    w_dec_valid = 1'b1;
    w_dec_step  = '0;
    case (state_counter)
      5'd1:    w_dec_step = 5'd0;
      5'd3:    w_dec_step = 5'd1;
      5'd7:    w_dec_step = 5'd2;
      5'd15:   w_dec_step = 5'd3;
      5'd31:   w_dec_step = 5'd4;
      5'd30:   w_dec_step = 5'd5;
      5'd29:   w_dec_step = 5'd6;
      5'd26:   w_dec_step = 5'd7;
      5'd21:   w_dec_step = 5'd8;
      5'd10:   w_dec_step = 5'd9;
      5'd20:   w_dec_step = 5'd10;
      5'd9:    w_dec_step = 5'd11;
      5'd19:   w_dec_step = 5'd12;
      5'd6:    w_dec_step = 5'd13;
      5'd12:   w_dec_step = 5'd14;
      5'd24:   w_dec_step = 5'd15;
      5'd17:   w_dec_step = 5'd16;
      5'd2:    w_dec_step = 5'd17;
      5'd4:    w_dec_step = 5'd18;
      5'd8:    w_dec_step = 5'd19;
      default: w_dec_valid = 1'b0;
    endcase
  end

  assign w_mismatch = !w_dec_valid || (w_dec_step != r_step);
`else
  logic w_unused_inputs;
  assign w_unused_inputs = ^{state_counter, err_clr};
  assign w_mismatch      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_step  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_step  <= w_step_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_RUN;
          w_step_nxt  = '0;
        end
      end
      S_RUN: begin
        // abort beats both a mismatch and completion on the same step
        if (abort) begin
          w_state_nxt = S_IDLE;
          w_step_nxt  = '0;
        end else if (w_mismatch) begin
          w_state_nxt = S_ERR;
          w_step_nxt  = '0;
        end else if (r_step == LAST_STEP) begin
          w_state_nxt = S_DONE;
          w_step_nxt  = '0;
        end else begin
          w_step_nxt = r_step + 5'd1;
        end
      end
      S_DONE: begin
        if (done_ack) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ERR: begin
`ifdef SEQ_CHECK_EN
        if (err_clr) begin
          w_state_nxt = S_IDLE;
        end
`else
        w_state_nxt = S_IDLE;
`endif
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_step_nxt  = '0;
      end
    endcase
  end

  assign w_run       = (r_state == S_RUN);
  assign start_ready = (r_state == S_IDLE);
  assign busy        = w_run;
  assign en_signal   = w_run;
  assign done        = (r_state == S_DONE);
  assign seq_err     = (r_state == S_ERR);

  // Decode is gated by RUN so every index and enable reads 0 elsewhere.
  assign step_idx    = w_run ? r_step : '0;
  assign round_idx   = w_run ? r_step[4:1] : '0;
  assign phase       = w_run & r_step[0];
  assign last_round  = w_run & (r_step[4:1] == LAST_ROUND);
  assign key_exp_en  = w_run & ~r_step[0];
  assign mix_en      = w_run & r_step[0] & (r_step[4:1] != LAST_ROUND);

endmodule

// File: tb/tb_aes_step_sequencer.sv
module tb_aes_step_sequencer;

  logic clk = 1'b0;
  logic rst;
  logic start20, start4, abort, done_ack, err_clr;

  logic [4:0] sc_a, sc_b;
  logic       sr_a, done_a, en_a, busy_a, ph_a, last_a, key_a, mix_a, err_a;
  logic [4:0] step_a;
  logic [3:0] round_a;
  logic       sr_b, done_b, en_b, busy_b, ph_b, last_b, key_b, mix_b, err_b;
  logic [4:0] step_b;
  logic [3:0] round_b;

  int total = 0;
  int bad   = 0;

  int idx_a = 0;
  int idx_b = 0;
  logic       force_on = 1'b0;
  int         force_idx = 0;
  logic [4:0] force_val = 5'd0;

  logic [12:0] q[$];
  logic [12:0] obs_a, obs_b;
  logic [4:0]  ctl_a, ctl_b;

  assign obs_a = {step_a, round_a, ph_a, last_a, key_a, mix_a};
  assign obs_b = {step_b, round_b, ph_b, last_b, key_b, mix_b};
  // {start_ready, en_signal, busy, done, seq_err}
  assign ctl_a = {sr_a, en_a, busy_a, done_a, err_a};
  assign ctl_b = {sr_b, en_b, busy_b, done_b, err_b};

  always #5 clk = ~clk;

  aes_step_sequencer #(.NUM_STEPS(20)) u_a (
    .clk(clk), .rst(rst), .start(start20), .start_ready(sr_a), .abort(abort),
    .done(done_a), .done_ack(done_ack), .err_clr(err_clr), .state_counter(sc_a),
    .en_signal(en_a), .busy(busy_a), .step_idx(step_a), .round_idx(round_a),
    .phase(ph_a), .last_round(last_a), .key_exp_en(key_a), .mix_en(mix_a),
    .seq_err(err_a)
  );

  aes_step_sequencer #(.NUM_STEPS(4)) u_b (
    .clk(clk), .rst(rst), .start(start4), .start_ready(sr_b), .abort(abort),
    .done(done_b), .done_ack(done_ack), .err_clr(err_clr), .state_counter(sc_b),
    .en_signal(en_b), .busy(busy_b), .step_idx(step_b), .round_idx(round_b),
    .phase(ph_b), .last_round(last_b), .key_exp_en(key_b), .mix_en(mix_b),
    .seq_err(err_b)
  );

  function automatic logic [4:0] tbl(input int i);
    case (i)
      0: tbl = 5'd1;   1: tbl = 5'd3;   2: tbl = 5'd7;   3: tbl = 5'd15;
      4: tbl = 5'd31;  5: tbl = 5'd30;  6: tbl = 5'd29;  7: tbl = 5'd26;
      8: tbl = 5'd21;  9: tbl = 5'd10; 10: tbl = 5'd20; 11: tbl = 5'd9;
      12: tbl = 5'd19; 13: tbl = 5'd6; 14: tbl = 5'd12; 15: tbl = 5'd24;
      16: tbl = 5'd17; 17: tbl = 5'd2; 18: tbl = 5'd4;  19: tbl = 5'd8;
      default: tbl = 5'd0;
    endcase
  endfunction

  // Step counter models: hold code 1 while disabled, advance one code per clk.
  always @(posedge clk) begin
    if (!en_a) idx_a <= 0;
    else       idx_a <= (idx_a == 19) ? 0 : idx_a + 1;
    if (!en_b) idx_b <= 0;
    else       idx_b <= (idx_b == 19) ? 0 : idx_b + 1;
  end

  always_comb begin
    sc_a = tbl(idx_a);
    if (force_on && idx_a == force_idx) sc_a = force_val;
    sc_b = tbl(idx_b);
  end

  // Expected decode {step, round, phase, last_round, key_exp_en, mix_en}.
  function automatic logic [12:0] mk_exp(input int s, input int nrounds);
    logic [3:0] r;
    logic       ph, last;
    r    = 4'(s / 2);
    ph   = (s % 2) == 1;
    last = (s / 2) == nrounds - 1;
    mk_exp = {5'(s), r, ph, last, !ph, ph && !last};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    total++;
    if (ctl_a !== 5'b10000) begin bad++; $display("FAIL reset_ctl_a: got %b want %b", ctl_a, 5'b10000); end
    total++;
    if (obs_a !== 13'd0) begin bad++; $display("FAIL reset_dec_a: got %h want %h", obs_a, 13'd0); end
    total++;
    if (ctl_b !== 5'b10000) begin bad++; $display("FAIL reset_ctl_b: got %b want %b", ctl_b, 5'b10000); end
    total++;
    if (obs_b !== 13'd0) begin bad++; $display("FAIL reset_dec_b: got %h want %h", obs_b, 13'd0); end
  endtask

  // Full 20-step run with start pulses during RUN and start held with done_ack.
  task automatic test_nominal;
    logic [12:0] e;
    for (int s = 0; s < 20; s++) q.push_back(mk_exp(s, 10));
    start20 = 1'b1;
    tick;
    start20 = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (c == 5) start20 = 1'b1;
      if (c == 9) start20 = 1'b0;
      total++;
      if (ctl_a !== 5'b01100) begin bad++; $display("FAIL nom_ctl c=%0d: got %b want %b", c, ctl_a, 5'b01100); end
      total++;
      if (q.size() == 0) begin bad++; $display("FAIL nom_queue c=%0d: got empty want entry", c); end
      else begin
        e = q.pop_front();
        if (obs_a !== e) begin bad++; $display("FAIL nom_dec c=%0d: got %h want %h", c, obs_a, e); end
      end
      if (c >= 19) begin
        total++;
        if (last_a !== 1'b1) begin bad++; $display("FAIL nom_last c=%0d: got %b want 1", c, last_a); end
      end
      if (c == 20) begin
        total++;
        if (mix_a !== 1'b0) begin bad++; $display("FAIL nom_mix19: got %b want 0", mix_a); end
      end
      tick;
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (ctl_a !== 5'b00010 || obs_a !== 13'd0) begin
        bad++; $display("FAIL nom_done i=%0d: got %b/%h want 00010/0", i, ctl_a, obs_a);
      end
      if (i < 3) tick;
    end
    done_ack = 1'b1;
    start20  = 1'b1;
    tick;
    done_ack = 1'b0;
    start20  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      total++;
      if (ctl_a !== 5'b10000) begin bad++; $display("FAIL nom_ack i=%0d: got %b want 10000", i, ctl_a); end
      tick;
    end
  endtask

  task automatic test_short;
    logic [12:0] e;
    for (int s = 0; s < 4; s++) q.push_back(mk_exp(s, 2));
    start4 = 1'b1;
    tick;
    start4 = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      total++;
      if (ctl_b !== 5'b01100) begin bad++; $display("FAIL short_ctl c=%0d: got %b want 01100", c, ctl_b); end
      total++;
      if (q.size() == 0) begin bad++; $display("FAIL short_queue c=%0d: got empty want entry", c); end
      else begin
        e = q.pop_front();
        if (obs_b !== e) begin bad++; $display("FAIL short_dec c=%0d: got %h want %h", c, obs_b, e); end
      end
      total++;
      if (sc_b !== tbl(c - 1)) begin bad++; $display("FAIL short_code c=%0d: got %0d want %0d", c, sc_b, tbl(c - 1)); end
      tick;
    end
    total++;
    if (ctl_b !== 5'b00010) begin bad++; $display("FAIL short_done: got %b want 00010", ctl_b); end
    done_ack = 1'b1;
    tick;
    done_ack = 1'b0;
    total++;
    if (ctl_b !== 5'b10000) begin bad++; $display("FAIL short_ack: got %b want 10000", ctl_b); end
  endtask

  task automatic test_error;
    logic [12:0] e;
    force_idx = 4;
    force_val = 5'd5;
    force_on  = 1'b1;
`ifdef SEQ_CHECK_EN
    for (int s = 0; s < 5; s++) q.push_back(mk_exp(s, 10));
    start20 = 1'b1;
    tick;
    start20 = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      total++;
      if (ctl_a !== 5'b01100) begin bad++; $display("FAIL err_run c=%0d: got %b want 01100", c, ctl_a); end
      e = q.pop_front();
      total++;
      if (obs_a !== e) begin bad++; $display("FAIL err_dec c=%0d: got %h want %h", c, obs_a, e); end
      tick;
    end
    force_on = 1'b0;
    total++;
    if (ctl_a !== 5'b00001) begin bad++; $display("FAIL err_enter: got %b want 00001", ctl_a); end
    for (int i = 0; i < 10; i++) begin
      start20  = (i % 2) == 0;
      abort    = 1'b1;
      done_ack = 1'b1;
      tick;
      total++;
      if (ctl_a !== 5'b00001) begin bad++; $display("FAIL err_hold i=%0d: got %b want 00001", i, ctl_a); end
    end
    start20  = 1'b0;
    abort    = 1'b0;
    done_ack = 1'b0;
    err_clr  = 1'b1;
    tick;
    err_clr  = 1'b0;
    total++;
    if (ctl_a !== 5'b10000) begin bad++; $display("FAIL err_clr: got %b want 10000", ctl_a); end
`else
    for (int s = 0; s < 20; s++) q.push_back(mk_exp(s, 10));
    start20 = 1'b1;
    tick;
    start20 = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      total++;
      if (ctl_a !== 5'b01100) begin bad++; $display("FAIL off_run c=%0d: got %b want 01100", c, ctl_a); end
      e = q.pop_front();
      total++;
      if (obs_a !== e) begin bad++; $display("FAIL off_dec c=%0d: got %h want %h", c, obs_a, e); end
      tick;
    end
    force_on = 1'b0;
    total++;
    if (ctl_a !== 5'b00010) begin bad++; $display("FAIL off_done: got %b want 00010", ctl_a); end
    err_clr  = 1'b1;
    done_ack = 1'b1;
    tick;
    err_clr  = 1'b0;
    done_ack = 1'b0;
    total++;
    if (ctl_a !== 5'b10000) begin bad++; $display("FAIL off_ack: got %b want 10000", ctl_a); end
`endif
  endtask

  task automatic test_abort;
    logic [12:0] e;
    force_idx = 7;
    force_val = 5'd5;
    force_on  = 1'b1;
    for (int s = 0; s < 8; s++) q.push_back(mk_exp(s, 10));
    start20 = 1'b1;
    tick;
    start20 = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      total++;
      if (ctl_a !== 5'b01100) begin bad++; $display("FAIL abort_run c=%0d: got %b want 01100", c, ctl_a); end
      e = q.pop_front();
      total++;
      if (obs_a !== e) begin bad++; $display("FAIL abort_dec c=%0d: got %h want %h", c, obs_a, e); end
      if (c == 8) abort = 1'b1;
      tick;
    end
    abort    = 1'b0;
    force_on = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (ctl_a !== 5'b10000 || obs_a !== 13'd0) begin
        bad++; $display("FAIL abort_idle i=%0d: got %b/%h want 10000/0", i, ctl_a, obs_a);
      end
      tick;
    end
    test_nominal();
  endtask

  task automatic test_reset_mid;
    logic [12:0] e;
    for (int s = 0; s < 13; s++) q.push_back(mk_exp(s, 10));
    start20 = 1'b1;
    tick;
    start20 = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      total++;
      if (ctl_a !== 5'b01100) begin bad++; $display("FAIL rmid_run c=%0d: got %b want 01100", c, ctl_a); end
      e = q.pop_front();
      total++;
      if (obs_a !== e) begin bad++; $display("FAIL rmid_dec c=%0d: got %h want %h", c, obs_a, e); end
      if (c < 13) tick;
    end
    #2;
    rst = 1'b0;
    #1;
    total++;
    if (ctl_a !== 5'b10000 || obs_a !== 13'd0) begin
      bad++; $display("FAIL rmid_async: got %b/%h want 10000/0", ctl_a, obs_a);
    end
    @(negedge clk);
    rst = 1'b1;
    tick;
    total++;
    if (ctl_a !== 5'b10000) begin bad++; $display("FAIL rmid_release: got %b want 10000", ctl_a); end
    test_nominal();
  endtask

  initial begin
    rst      = 1'b0;
    start20  = 1'b0;
    start4   = 1'b0;
    abort    = 1'b0;
    done_ack = 1'b0;
    err_clr  = 1'b0;
    #12;
    test_reset();
    rst = 1'b1;
    tick;
    test_nominal();
    test_short();
    test_error();
    test_abort();
    test_reset_mid();
    total++;
    if (q.size() != 0) begin bad++; $display("FAIL queue_left: got %0d want 0", q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
